// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard and busy count.
// Optional same-cycle write bypass: define REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            alloc_valid,
    input  logic [AW-1:0]   alloc_rd,
    output logic            alloc_ready,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] mem [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt;
    logic wr_eff;
    logic al_eff;
    logic al_new;
    logic rel;

    function automatic logic is_zero(input logic [AW-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    always_comb begin
        wr_eff = we & ~is_zero(rd);
`ifdef REGFILE_BYPASS_EN
        alloc_ready = rst_n & (~busy[alloc_rd] | (wr_eff & (rd == alloc_rd)));
`else
        alloc_ready = rst_n & ~busy[alloc_rd];
`endif
        al_eff = alloc_valid & alloc_ready & ~is_zero(alloc_rd);
        // Only a previously idle register grows the count.
        al_new = al_eff & ~busy[alloc_rd];
        rel    = wr_eff & busy[rd] & ~(al_eff & (alloc_rd == rd));
        busy_nxt = busy;
        if (wr_eff) busy_nxt[rd] = 1'b0;
        if (al_eff) busy_nxt[alloc_rd] = 1'b1;
    end

    always_comb begin
        rd1   = '0;
        rd2   = '0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (rst_n) begin
            if (!is_zero(rs1)) begin
                rd1   = mem[rs1];
                busy1 = busy[rs1];
            end
            if (!is_zero(rs2)) begin
                rd2   = mem[rs2];
                busy2 = busy[rs2];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_eff && rd == rs1) begin
                rd1   = wd;
                busy1 = 1'b0;
            end
            if (wr_eff && rd == rs2) begin
                rd2   = wd;
                busy2 = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (wr_eff) mem[rd] <= wd;
            busy <= busy_nxt;
            if (al_new && !rel) cnt <= cnt + 1'b1;
            else if (rel && !al_new) cnt <= cnt - 1'b1;
        end
    end

    assign busy_cnt = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb against an array-based model.
// Also checks the 8-entry build for busy count saturation.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic we = 1'b0;
    logic [AW-1:0] rd = '0;
    logic [XLEN-1:0] wd = '0;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic alloc_valid = 1'b0;
    logic [AW-1:0] alloc_rd = '0;
    logic [XLEN-1:0] rd1, rd2;
    logic busy1, busy2, alloc_ready;
    logic [AW:0] busy_cnt;

    logic we8 = 1'b0;
    logic [2:0] rd8 = '0;
    logic [XLEN-1:0] wd8 = '0;
    logic [2:0] rs18 = '0;
    logic [2:0] rs28 = '0;
    logic alloc_valid8 = 1'b0;
    logic [2:0] alloc_rd8 = '0;
    logic [XLEN-1:0] rd18, rd28;
    logic busy18, busy28, alloc_ready8;
    logic [3:0] busy_cnt8;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] m_mem [NREGS];
    bit m_busy [NREGS];

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .rd(rd), .wd(wd),
        .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .alloc_valid(alloc_valid),
        .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
        .busy_cnt(busy_cnt)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(8), .ZERO_REG(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .we(we8), .rd(rd8), .wd(wd8),
        .rs1(rs18), .rs2(rs28), .rd1(rd18), .rd2(rd28),
        .busy1(busy18), .busy2(busy28), .alloc_valid(alloc_valid8),
        .alloc_rd(alloc_rd8), .alloc_ready(alloc_ready8),
        .busy_cnt(busy_cnt8)
    );

    function automatic logic [XLEN-1:0] e_rd(input logic [AW-1:0] s);
        if (!rst_n || s == 0) return '0;
        if (BYP && we && rd == s) return wd;
        return m_mem[s];
    endfunction

    function automatic logic e_busy(input logic [AW-1:0] s);
        if (!rst_n || s == 0) return 1'b0;
        if (BYP && we && rd == s) return 1'b0;
        return m_busy[s];
    endfunction

    function automatic logic e_ready(input logic [AW-1:0] a);
        if (!rst_n) return 1'b0;
        if (a == 0) return 1'b1;
        return !m_busy[a] || (BYP && we && rd == a);
    endfunction

    function automatic int e_cnt();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic tick();
        bit ok;
        @(posedge clk);
        ok = e_ready(alloc_rd);
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                m_mem[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && rd != 0) begin
                m_mem[rd] = wd;
                m_busy[rd] = 1'b0;
            end
            if (alloc_valid && ok && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we = 1'b1; rd = 5; wd = 32'hFFFFFFFF;
        alloc_valid = 1'b1; alloc_rd = 6;
        rs1 = 5; rs2 = 6;
        tick();
        #1;
        checks++;
        if (rd1 !== '0 || busy2 !== 1'b0 || alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: rd1=%h busy2=%b ready=%b want 0/0/0",
                     rd1, busy2, alloc_ready);
        end
        tick();
        rst_n = 1'b1; we = 1'b0; alloc_valid = 1'b0;
        #1;
        checks++;
        if (rd1 !== '0 || busy_cnt !== '0 || busy_cnt8 !== '0) begin
            errors++;
            $display("FAIL reset_after: rd1=%h cnt=%0d cnt8=%0d want 0/0/0",
                     rd1, busy_cnt, busy_cnt8);
        end
    endtask

    task automatic test_basic();
        we = 1'b1; rd = 5; wd = 32'hDEADBEEF;
        tick();
        rd = 10; wd = 32'hCAFEBABE;
        tick();
        we = 1'b0; rs1 = 5; rs2 = 10;
        #1;
        checks++;
        if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hCAFEBABE) begin
            errors++;
            $display("FAIL basic_rw: rd1=%h rd2=%h want deadbeef/cafebabe",
                     rd1, rd2);
        end
        we = 1'b1; rd = 0; wd = 32'h12345678;
        tick();
        we = 1'b0; rs1 = 0;
        #1;
        checks++;
        if (rd1 !== '0) begin
            errors++;
            $display("FAIL zero_reg: rd1=%h want 0", rd1);
        end
    endtask

    task automatic test_scoreboard();
        alloc_valid = 1'b1; alloc_rd = 7;
        tick();
        alloc_valid = 1'b0; rs1 = 7;
        #1;
        checks++;
        if (busy1 !== 1'b1 || busy_cnt !== 6'd1 || alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL alloc_r7: busy1=%b cnt=%0d ready=%b want 1/1/0",
                     busy1, busy_cnt, alloc_ready);
        end
        we = 1'b1; rd = 7; wd = 32'h0000_00AA;
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b0 || rd1 !== 32'hAA || busy_cnt !== 6'd0) begin
            errors++;
            $display("FAIL release_r7: busy1=%b rd1=%h cnt=%0d want 0/aa/0",
                     busy1, rd1, busy_cnt);
        end
    endtask

    task automatic test_simultaneous();
        we = 1'b1; rd = 3; wd = 32'h33;
        alloc_valid = 1'b1; alloc_rd = 3; rs1 = 3;
        tick();
        we = 1'b0; alloc_valid = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b1 || rd1 !== 32'h33 || busy_cnt !== 6'd1) begin
            errors++;
            $display("FAIL same_reg: busy1=%b rd1=%h cnt=%0d want 1/33/1",
                     busy1, rd1, busy_cnt);
        end
        alloc_valid = 1'b1; alloc_rd = 9;
        tick();
        we = 1'b1; rd = 9; wd = 32'h99; alloc_rd = 4;
        tick();
        we = 1'b0; alloc_valid = 1'b0; rs1 = 4; rs2 = 9;
        #1;
        checks++;
        if (busy_cnt !== 6'd2 || busy1 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL diff_reg: cnt=%0d b1=%b b2=%b want 2/1/0",
                     busy_cnt, busy1, busy2);
        end
        we = 1'b1; rd = 3;
        tick();
        rd = 4;
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (busy_cnt !== 6'd0) begin
            errors++;
            $display("FAIL drain: cnt=%0d want 0", busy_cnt);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; rd = 12; wd = 32'h11;
        tick();
        wd = 32'h55AA55AA; rs1 = 12;
        #1;
        checks++;
        if (rd1 !== (BYP ? 32'h55AA55AA : 32'h11) || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL bypass_same: rd1=%h busy1=%b want %h/0",
                     rd1, busy1, BYP ? 32'h55AA55AA : 32'h11);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rd1 !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL bypass_next: rd1=%h want 55aa55aa", rd1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            rd = AW'($urandom);
            wd = $urandom;
            alloc_valid = 1'($urandom_range(0, 1));
            alloc_rd = ($urandom_range(0, 5) == 0) ? rd : AW'($urandom);
            rs1 = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom);
            rs2 = ($urandom_range(0, 3) == 0) ? alloc_rd : AW'($urandom);
            #1;
            checks++;
            if (rd1 !== e_rd(rs1) || rd2 !== e_rd(rs2) ||
                busy1 !== e_busy(rs1) || busy2 !== e_busy(rs2) ||
                alloc_ready !== e_ready(alloc_rd) ||
                busy_cnt !== 6'(e_cnt())) begin
                errors++;
                $display("FAIL rand_%0d: rd1=%h/%h rd2=%h/%h b=%b%b/%b%b rdy=%b/%b cnt=%0d/%0d",
                         n, rd1, e_rd(rs1), rd2, e_rd(rs2), busy1, busy2,
                         e_busy(rs1), e_busy(rs2), alloc_ready,
                         e_ready(alloc_rd), busy_cnt, e_cnt());
            end
            tick();
        end
        we = 1'b0; alloc_valid = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 1; i < 8; i++) begin
            alloc_valid8 = 1'b1; alloc_rd8 = 3'(i);
            tick();
        end
        alloc_valid8 = 1'b0;
        #1;
        checks++;
        if (busy_cnt8 !== 4'd7) begin
            errors++;
            $display("FAIL sat_full: cnt=%0d want 7", busy_cnt8);
        end
        alloc_valid8 = 1'b1; alloc_rd8 = 0;
        #1;
        checks++;
        if (alloc_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL sat_r0_ready: ready=%b want 1", alloc_ready8);
        end
        tick();
        alloc_valid8 = 1'b0; alloc_rd8 = 3;
        #1;
        checks++;
        if (busy_cnt8 !== 4'd7 || alloc_ready8 !== 1'b0) begin
            errors++;
            $display("FAIL sat_r0_cnt: cnt=%0d ready=%b want 7/0",
                     busy_cnt8, alloc_ready8);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_scoreboard();
        test_simultaneous();
        test_bypass();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated scoreboard for the single-cycle RISC-V core and its planned multi-cycle extensions. It provides two combinational read ports and one write port, with register width and depth set by parameters. A per-register busy bit is set when a long-latency operation reserves a destination and cleared when that operation writes back. It also keeps a running count of busy registers, so the decode stage can detect RAW/WAW hazards and stall.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, 2..64
- AW, $clog2(NREGS), register index width; derived, never overridden
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary storage

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- we  in  1  write enable
- rd  in  AW  write index
- wd  in  XLEN  write data
- rs1  in  AW  read index, port 1
- rs2  in  AW  read index, port 2
- rd1  out  XLEN  read data, port 1, combinational
- rd2  out  XLEN  read data, port 2, combinational
- busy1  out  1  register rs1 has a pending writer
- busy2  out  1  register rs2 has a pending writer
- alloc_valid  in  1  request to reserve register alloc_rd
- alloc_rd  in  AW  register to reserve
- alloc_ready  out  1  reservation can be accepted this cycle
- busy_cnt  out  AW+1  number of registers currently busy

## Operation
- Reset (rst_n low at a rising edge):
  - all registers cleared to 0
  - all busy bits cleared
  - busy_cnt = 0
  - we and alloc_valid are ignored
  - from the first reset edge onward: rd1 = rd2 = 0, busy1 = busy2 = 0, alloc_ready = 0 while rst_n is low
- Write: when we = 1 at a rising edge, mem[rd] <= wd and busy[rd] is cleared.
  - Writing a register that is not busy is legal; busy stays 0.
- Writes to register 0 are discarded when ZERO_REG = 1. Reads of register 0 then return 0, and busy1/busy2 for index 0 are always 0.
- Allocation handshake:
  - alloc_ready = rst_n & ~busy[alloc_rd]
  - A transfer occurs when alloc_valid & alloc_ready, and sets busy[alloc_rd] at the edge.
  - Allocating an already-busy register is refused (alloc_ready = 0) until its writeback completes.
- Allocating register 0 with ZERO_REG = 1: alloc_ready = 1, and the transfer has no effect on busy or busy_cnt.
- Same register, alloc transfer and write in the same cycle: the write lands and busy ends at 1 (set wins).
- busy_cnt per edge:
  - +1 on an effective allocation
  - −1 on a write that clears a set busy bit
  - both in the same cycle: unchanged for different registers; +0 for the same register
  - Never exceeds NREGS; never wraps.
- Read ports are independent. rs1 = rs2 returns identical data and busy flags.

## Timing
- Reads are combinational from the current array and busy state. There is zero-cycle latency from rs1/rs2 to rd1/rd2/busy1/busy2.
- A write is visible on the read ports the cycle after the edge. See Configuration for same-cycle bypass.
- An allocation is visible on busy1/busy2/alloc_ready the cycle after the handshake edge.
- A release (write) is visible on busy1/busy2 the cycle after the edge, unless bypass is enabled.
- If reset is asserted mid-operation, it overrides any concurrent write or allocation at that edge. No pending reservation survives reset.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When we = 1, rst_n = 1 and rd == rs1 (excluding register 0 when ZERO_REG = 1), rd1 = wd and busy1 = 0 in the same cycle. Port 2 behaves the same way.
  - alloc_ready also treats a same-cycle write to alloc_rd as a release.
- REGFILE_BYPASS_EN undefined:
  - Read ports show only state from before the edge.
  - A register being written this cycle still reads its old value and busy flag until the next cycle.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with we = 1, rd = 5, wd = 32'hFFFFFFFF → after release, rs1 = 5 reads 0, and busy_cnt = 0.
- Basic write/read:
  - write 32'hDEADBEEF to r5 and 32'hCAFEBABE to r10 on consecutive edges, then read with rs1 = 5, rs2 = 10 → rd1 = DEADBEEF, rd2 = CAFEBABE.
  - write 32'h12345678 to r0 → r0 reads 0.
- Scoreboard:
  - allocate r7 → next cycle busy1 = 1 (rs1 = 7), busy_cnt = 1.
  - a second alloc of r7 sees alloc_ready = 0.
  - write r7 = 32'h0000_00AA → next cycle busy1 = 0, rd1 = AA, busy_cnt = 0.
- Simultaneous events:
  - allocate r3 while writing r3 → busy[r3] = 1, data updated, busy_cnt +1.
  - allocate r4 while writing busy r9 → busy_cnt unchanged.
- Bypass (REGFILE_BYPASS_EN): we = 1, rd = 12, wd = 32'h55AA55AA, rs1 = 12 → rd1 = 55AA55AA in the same cycle. Without the macro, rd1 shows the old value until the next cycle.
- Saturation: with NREGS = 8 and ZERO_REG = 1, allocate r1..r7 → busy_cnt = 7. A further alloc to r0 is accepted and busy_cnt remains 7.
